// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with registered NZCV flags and a start/busy/done handshake.
// Define ALU_MC_MUL_EN to build the iterative shift-add multiplier for op 1010.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             flag_we,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] add_a, add_b, alu_res;
    logic             add_cin, arith, legal;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [3:0]       arith_flags, logic_flags;

    always_comb begin : decode
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        arith   = 1'b0;
        legal   = 1'b1;
        alu_res = '0;
        case (op)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a ^ b;
            4'b0010: begin arith = 1'b1; add_a = a; add_b = ~b; add_cin = 1'b1;       end
            4'b0011: begin arith = 1'b1; add_a = b; add_b = ~a; add_cin = 1'b1;       end
            4'b0100: begin arith = 1'b1; add_a = a; add_b = b;                         end
            4'b0101: begin arith = 1'b1; add_a = a; add_b = b;  add_cin = flags_q[1]; end
            4'b0110: begin arith = 1'b1; add_a = a; add_b = ~b; add_cin = flags_q[1]; end
            4'b0111: begin arith = 1'b1; add_a = b; add_b = ~a; add_cin = flags_q[1]; end
            4'b1000: alu_res = a | b;
            4'b1001: alu_res = a & ~b;
            default: legal = 1'b0;
        endcase
        sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        if (arith) alu_res = sum[WIDTH-1:0];
    end

    assign ovf         = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
    assign arith_flags = {alu_res[WIDTH-1], alu_res == '0, sum[WIDTH], ovf};
    assign logic_flags = {alu_res[WIDTH-1], alu_res == '0, flags_q[1:0]};

`ifdef ALU_MC_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fwe_q, fwe_d;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy    = (state_q == S_MUL);
`else
    assign busy    = 1'b0;
`endif

    always_comb begin : next_state
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef ALU_MC_MUL_EN
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        fwe_d     = fwe_q;
        if (state_q == S_MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            // Final iteration's partial product goes straight into result
            if (cnt_q == CNT_W'(1)) begin
                result_d = acc_sum;
                done_d   = 1'b1;
                state_d  = S_IDLE;
                if (fwe_q) flags_d = {acc_sum[WIDTH-1], acc_sum == '0, flags_q[1:0]};
            end
        end else if (start && op == 4'b1010) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            fwe_d    = flag_we;
            state_d  = S_MUL;
        end else
`endif
        if (start) begin
            done_d = 1'b1;
            if (legal) begin
                result_d = alu_res;
                if (flag_we) flags_d = arith ? arith_flags : logic_flags;
            end else begin
                result_d  = '0;
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_MC_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            fwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fwe_q    <= fwe_d;
        end
    end
`endif

    assign result  = result_q;
    assign flags   = flags_q;
    assign done    = done_q;
    assign illegal = illegal_q;
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle ALU, placed in the execute stage of the multi-cycle datapath.
- Adds a registered NZCV flag register, true carry-in for ADC/SBC/RSC, and ORR/BIC/RSB.
- Adds an optional iterative shift-add multiplier.
- Uses a start/busy/done handshake so the controller can stall on long operations.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled with a, b, op and flag_we on a rising edge while busy=0
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  4  operation code (see Behaviour)
flag_we  in  1  update the flag register for this operation
busy  out  1  multiply in progress; start is ignored while high
done  out  1  one-cycle pulse: result is valid and flags are updated
illegal  out  1  one-cycle pulse coincident with done for an undefined op
result  out  WIDTH  registered result; held until the next done
flags  out  4  registered {N,Z,C,V}

Behaviour:
- Reset (synchronous): result=0, flags=0000, busy=0, done=0, illegal=0, state=IDLE, counter=0.
  - Reset during MUL aborts it: no done pulse; flags and result are cleared.
- Op codes:
  - 0000 AND, 0001 EOR, 0010 SUB (a-b), 0011 RSB (b-a)
  - 0100 ADD, 0101 ADC (a+b+C), 0110 SBC (a+~b+C), 0111 RSC (b+~a+C)
  - 1000 ORR, 1001 BIC (a&~b), 1010 MUL, 1011-1111 undefined
- Arithmetic:
  - Computed in a WIDTH+1-bit adder. SUB = a+~b+1.
  - C = adder bit WIDTH (ARM convention: C=1 means no borrow).
  - V = (opA[MSB]==opB'[MSB]) && (res[MSB]!=opA[MSB]), where opA/opB' are the actual adder inputs after inversion.
  - C used as carry-in is the flag register value at the start edge.
- Flags when flag_we=1 at the start edge:
  - Arithmetic ops update N, Z, C, V.
  - Logical ops and MUL update N and Z only; C and V are preserved.
  - Undefined ops never touch flags.
  - When flag_we=0, flags are unchanged.
  - N = res[WIDTH-1]; Z = (res==0).
- State machine IDLE/MUL:
  - IDLE, start=1, op!=1010: result and flags are written at the same edge; done=1 for exactly the following cycle. Latency 1; back-to-back starts every cycle are accepted.
  - IDLE, start=1, op=1010: latch a into the multiplicand register, b into the multiplier register, clear the accumulator, counter=WIDTH, busy=1, go to MUL.
  - MUL, each cycle:
    - If multiplier[0]=1, acc += mcand (mod 2^WIDTH).
    - mcand <<= 1; mplier >>= 1; counter--.
    - On the edge where counter goes 1->0: result=acc (final), flags written per flag_we, done=1 for one cycle, busy=0, return to IDLE.
  - MUL timing: start sampled at edge k; done is visible after edge k+WIDTH; busy is high for WIDTH cycles.
  - MUL result is the low WIDTH bits of a*b (identical for signed and unsigned).
  - A start seen in the same cycle that done is high (state IDLE) is accepted.
  - A start while busy is dropped, not queued.
- Undefined op: result=0, done=1 and illegal=1 for one cycle, flags unchanged.
- done and illegal are low in every cycle not listed above.
- result and flags change only on a done edge or reset.

Optional Feature:
ALU_MC_MUL_EN
- Defined: MUL (1010) is implemented as above, including the counter, the shift registers and the MUL state.
- Undefined: no multiplier hardware is built; 1010 is treated as an undefined op (1-cycle done+illegal, result=0, flags unchanged), and busy is tied to 0.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001, flag_we=1 -> result 0x00000000, flags 0110, done exactly one cycle after start.
- SUB 5-7 with flag_we=1 -> 0xFFFFFFFE, flags 1000. Then ADC 1+1 -> 0x00000002. Then SUB 7-5 (flags 0010), then ADC 1+1 -> 0x00000003.
- ADD 0x7FFFFFFF+1, flag_we=1 -> 0x80000000, flags 1001. Then AND 0xF0F0F0F0&0x0F0F0F0F with flag_we=1 -> 0, flags 0101 (C and V preserved). Then op 1111 -> result 0, illegal pulse, flags still 0101.
- MUL 0x00010000*0x00010001 (MUL_EN defined), flag_we=1 -> result 0x00010000, flags 0000. busy high for 32 cycles, done 32 cycles after start. A start pulsed mid-multiply is ignored: no extra done.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. Assert reset on iteration 10 of a second MUL -> busy=0, no done pulse, result=0, flags=0000 on the next cycle.
- Build without ALU_MC_MUL_EN: op 1010 with a=3, b=4 -> result 0, done+illegal one cycle later, busy never asserted.
